// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage sitting directly behind the program counter. It issues one
// instruction-memory read per PC value over a req/ack handshake, buffers the
// returned words (together with the address they came from) in a small FIFO,
// and presents the FIFO head to decode over a valid/ready handshake.
//
// pc_hold is fed back to the program counter: the PC only advances on the
// edge where its current value is captured into mem_addr, or when a jump
// (flush) loads a new target. A flush discards everything queued and marks
// any in-flight read so its data is thrown away when it returns.
//
// Ports
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   pc          in   current PC from the program counter
//   flush       in   jump taken this cycle (same signal as the PC selector)
//   halt        in   global halt; blocks new fetches only
//   pc_hold     out  combinational; PC must not change at this edge
//   mem_req     out  registered read request
//   mem_addr    out  registered read address, stable while mem_req is high
//   mem_ack     in   read completes this cycle, mem_rdata valid
//   mem_rdata   in   read data
//   inst_valid  out  queue head valid
//   inst_ready  in   decode accepts the head
//   inst        out  head instruction word
//   inst_pc     out  address the head instruction was fetched from
//
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pc,
  input  logic             flush,
  input  logic             halt,
  output logic             pc_hold,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc
);

  localparam int PW = $clog2(DEPTH);       // queue pointer width
  localparam int CW = $clog2(DEPTH + 1);   // occupancy width, holds 0..DEPTH

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // IDLE: nothing outstanding. REQ: outstanding, response will be queued.
  // DROP: outstanding, response belongs to a flushed path and is discarded.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e                       state_q,    state_d;
  logic                         mem_req_q,  mem_req_d;
  logic [WIDTH-1:0]             mem_addr_q, mem_addr_d;

  // Queue storage: instruction word and its fetch address per slot.
  logic [DEPTH-1:0][WIDTH-1:0]  data_q,     data_d;
  logic [DEPTH-1:0][WIDTH-1:0]  addr_q,     addr_d;
  logic [PW-1:0]                rd_ptr_q,   rd_ptr_d;
  logic [PW-1:0]                wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0]                count_q,    count_d;

  logic                         wr;
  logic                         pop;
  logic [CW-1:0]                occ_next;
  logic                         issue;

  // ---------------------------------------------------------------------------
  // Handshake decode, next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block can leave one unassigned and infer a latch.
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    data_d     = data_q;
    addr_d     = addr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    // A flush hides the head in the same cycle, which also suppresses the pop.
    inst_valid = (count_q != '0) && !flush;
    inst       = data_q[rd_ptr_q];
    inst_pc    = addr_q[rd_ptr_q];

    pop      = inst_valid && inst_ready;
    wr       = (state_q == REQ) && mem_ack && !flush;
    occ_next = count_q + CW'(wr) - CW'(pop);

    // Issuing only while occ_next < DEPTH reserves a slot for the response
    // of the new request, so a returning word can never find the queue full.
    issue = !halt && !flush
         && ((state_q == IDLE) || ((state_q == REQ) && mem_ack))
         && (occ_next < DEPTH_C);

    // Held in reset so the PC cannot move while the fetch stage is cleared.
    pc_hold = !reset_n || !(issue || flush);

    // Request FSM
    case (state_q)
      IDLE: begin
        if (issue) state_d = REQ;
      end
      REQ: begin
        if (flush) begin
          // A request is never withdrawn; an unanswered one is just disowned.
          state_d = mem_ack ? IDLE : DROP;
        end else if (mem_ack) begin
          state_d = issue ? REQ : IDLE;
        end
      end
      DROP: begin
        // The returning word is discarded and nothing is issued this cycle.
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    mem_req_d = (state_d != IDLE);
    if (issue) mem_addr_d = pc;

    // Instruction queue
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr) begin
        data_d[wr_ptr_q] = mem_rdata;
        addr_d[wr_ptr_q] = mem_addr_q;
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = occ_next;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      // NOTE: the queue storage is cleared as well, so inst/inst_pc read as
      // zero after reset rather than whatever the slots held before.
      data_q     <= '0;
      addr_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of the others, independent of statement order.
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Self-checking bench for instruction_fetch. The bench plays both the
// program counter and the instruction memory. A behavioural model keeps the
// outstanding read as {busy, keep, addr} and the instruction queue as a SV
// queue of {pc, data}; every cycle the DUT outputs are compared against it.
// Directed tables carry hand-derived expected values for streaming and
// backpressure, short hand-written sequences cover flush, halt and reset, and
// a randomized run closes out the test.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam int W     = 32;
  localparam int DEPTH = 2;

  logic         clock;
  logic         reset_n;
  logic [W-1:0] pc;
  logic         flush;
  logic         halt;
  logic         pc_hold;
  logic         mem_req;
  logic [W-1:0] mem_addr;
  logic         mem_ack;
  logic [W-1:0] mem_rdata;
  logic         inst_valid;
  logic         inst_ready;
  logic [W-1:0] inst;
  logic [W-1:0] inst_pc;

  instruction_fetch #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pc         (pc),
    .flush      (flush),
    .halt       (halt),
    .pc_hold    (pc_hold),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests  = 0;
  int failed = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [W-1:0] pc;
    logic [W-1:0] data;
  } entry_t;

  entry_t       mq[$];
  logic         m_out;     // a read is outstanding
  logic         m_keep;    // its data will be queued
  logic [W-1:0] m_addr;
  logic [W-1:0] m_pc;

  // Decisions taken at the sample point, applied after the edge.
  logic         p_flush, p_pop, p_push, p_ack, p_issue;
  logic [W-1:0] p_tgt, p_data;

  typedef struct {
    logic         h, f, a, r;
    logic         e_req;
    logic [W-1:0] e_addr;
    logic         e_valid;
    logic [W-1:0] e_ipc;
    logic         e_hold;
  } vec_t;

  vec_t stream_v[6];
  vec_t bp_v[8];

  function automatic logic [W-1:0] mem_fn(input logic [W-1:0] a);
    return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input logic h, f, a, r, e_req,
                              input logic [W-1:0] e_addr,
                              input logic e_valid,
                              input logic [W-1:0] e_ipc,
                              input logic e_hold);
    vec_t v;
    v.h = h; v.f = f; v.a = a; v.r = r;
    v.e_req = e_req; v.e_addr = e_addr;
    v.e_valid = e_valid; v.e_ipc = e_ipc; v.e_hold = e_hold;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, sample at the falling edge, compare with the
  // model and record what the model does at the coming rising edge.
  task automatic step(input logic h, f, a, r, input logic [W-1:0] tgt,
                      input logic dead);
    logic a_eff, e_valid, do_pop, do_push, can_issue;
    int   occ;
    a_eff      = a & m_out;   // memory only answers an outstanding read
    halt       = h;
    flush      = f;
    mem_ack    = a_eff;
    inst_ready = r;
    pc         = m_pc;
    mem_rdata  = dead ? 32'h0000_DEAD : mem_fn(m_addr);
    @(negedge clock);
    e_valid   = (mq.size() != 0) && !f;
    do_pop    = e_valid && r;
    do_push   = m_out && m_keep && a_eff && !f;
    occ       = mq.size() + int'(do_push) - int'(do_pop);
    can_issue = !h && !f && (!m_out || (m_keep && a_eff)) && (occ < DEPTH);
    check("mem_req", mem_req, m_out);
    if (m_out) check("mem_addr", mem_addr, m_addr);
    check("inst_valid", inst_valid, e_valid);
    if (e_valid) begin
      check("inst_pc", inst_pc, mq[0].pc);
      check("inst", inst, mq[0].data);
    end
    check("pc_hold", pc_hold, !(can_issue || f));
    p_flush = f;     p_pop = do_pop; p_push = do_push;
    p_ack   = a_eff; p_issue = can_issue;
    p_tgt   = tgt;   p_data = mem_rdata;
  endtask

  task automatic tick();
    entry_t e;
    @(posedge clock);
    #1;
    if (p_flush) begin
      mq.delete();
      if (m_out) begin
        if (p_ack) m_out = 1'b0;
        else       m_keep = 1'b0;
      end
      m_pc = p_tgt;
    end else begin
      if (p_pop) mq.delete(0);
      if (p_push) begin
        e.pc   = m_addr;
        e.data = p_data;
        mq.push_back(e);
      end
      if (p_ack) m_out = 1'b0;
      if (p_issue) begin
        m_out  = 1'b1;
        m_keep = 1'b1;
        m_addr = m_pc;
        m_pc   = m_pc + 1;
      end
    end
  endtask

  // Assert reset (mid-cycle), check the cleared outputs, release just after
  // a rising edge so the first model cycle lines up with the next edge.
  task automatic do_reset(input logic [W-1:0] start_pc);
    reset_n = 1'b0;
    halt = 1'b0; flush = 1'b0; mem_ack = 1'b0; inst_ready = 1'b0;
    mem_rdata = '0; pc = start_pc;
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, '0);
    check("rst_inst_pc", inst_pc, '0);
    check("rst_pc_hold", pc_hold, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    mq.delete();
    m_out = 1'b0; m_keep = 1'b0; m_addr = '0; m_pc = start_pc;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    step(v.h, v.f, v.a, v.r, '0, 1'b0);
    check({tag, "_req"}, mem_req, v.e_req);
    if (v.e_req) check({tag, "_addr"}, mem_addr, v.e_addr);
    check({tag, "_valid"}, inst_valid, v.e_valid);
    if (v.e_valid) begin
      check({tag, "_ipc"}, inst_pc, v.e_ipc);
      check({tag, "_inst"}, inst, mem_fn(v.e_ipc));
    end
    check({tag, "_hold"}, pc_hold, v.e_hold);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rp;
    reset_n = 1'b0;

    //               h f a r  req addr  valid ipc  hold
    stream_v[0] = mk(0,0,0,1, 0, 32'd0, 0, 32'd0, 0);
    stream_v[1] = mk(0,0,1,1, 1, 32'd0, 0, 32'd0, 0);
    stream_v[2] = mk(0,0,1,1, 1, 32'd1, 1, 32'd0, 0);
    stream_v[3] = mk(0,0,1,1, 1, 32'd2, 1, 32'd1, 0);
    stream_v[4] = mk(0,0,1,1, 1, 32'd3, 1, 32'd2, 0);
    stream_v[5] = mk(0,0,0,1, 1, 32'd4, 1, 32'd3, 1);

    bp_v[0] = mk(0,0,0,0, 0, 32'd0, 0, 32'd0, 0);
    bp_v[1] = mk(0,0,1,0, 1, 32'd0, 0, 32'd0, 0);
    bp_v[2] = mk(0,0,1,0, 1, 32'd1, 1, 32'd0, 1);
    bp_v[3] = mk(0,0,0,0, 0, 32'd0, 1, 32'd0, 1);
    bp_v[4] = mk(0,0,0,0, 0, 32'd0, 1, 32'd0, 1);
    bp_v[5] = mk(0,0,0,1, 0, 32'd0, 1, 32'd0, 0);
    bp_v[6] = mk(0,0,1,1, 1, 32'd2, 1, 32'd1, 0);
    bp_v[7] = mk(0,0,1,1, 1, 32'd3, 1, 32'd2, 0);

    // Streaming with zero-wait memory
    do_reset(32'd0);
    for (int i = 0; i < 6; i++) apply_vec(stream_v[i], "stream");

    // Backpressure: queue fills, PC freezes at 2, then drains in order
    do_reset(32'd0);
    for (int i = 0; i < 8; i++) apply_vec(bp_v[i], "bp");

    // Flush while a read to 0x10 is waiting; its 0xDEAD data must vanish
    do_reset(32'h10);
    step(0,0,0,1, '0, 0); tick();
    step(0,1,0,1, 32'h40, 0);
    check("flush_pc_hold", pc_hold, 1'b0);
    tick();
    step(0,0,0,1, '0, 0);
    check("drop_req", mem_req, 1'b1);
    check("drop_addr", mem_addr, 32'h10);
    tick();
    step(0,0,1,1, '0, 1);
    check("drop_ack_addr", mem_addr, 32'h10);
    check("drop_ack_valid", inst_valid, 1'b0);
    check("drop_ack_hold", pc_hold, 1'b1);
    tick();
    step(0,0,0,1, '0, 0); tick();
    step(0,0,1,1, '0, 0);
    check("jump_addr", mem_addr, 32'h40);
    tick();
    step(0,0,0,1, '0, 0);
    check("jump_inst_pc", inst_pc, 32'h40);
    check("no_dead", {31'd0, inst == 32'h0000_DEAD}, '0);
    tick();

    // Halt with a read outstanding
    do_reset(32'h20);
    step(0,0,0,0, '0, 0); tick();
    step(1,0,0,0, '0, 0);
    check("halt_hold0", pc_hold, 1'b1);
    tick();
    step(1,0,1,0, '0, 0);
    check("halt_hold1", pc_hold, 1'b1);
    tick();
    step(1,0,0,0, '0, 0);
    check("halt_valid", inst_valid, 1'b1);
    check("halt_ipc", inst_pc, 32'h20);
    check("halt_no_req", mem_req, 1'b0);
    check("halt_hold2", pc_hold, 1'b1);
    tick();
    step(1,0,0,1, '0, 0); tick();
    step(1,0,0,0, '0, 0);
    check("halt_drained", inst_valid, 1'b0);
    check("halt_hold3", pc_hold, 1'b1);
    tick();
    step(0,0,0,0, '0, 0);
    check("unhalt_hold", pc_hold, 1'b0);
    tick();
    step(0,0,0,0, '0, 0);
    check("unhalt_addr", mem_addr, 32'h21);
    tick();

    // Flush against a pop with the queue full
    do_reset(32'd0);
    step(0,0,0,0, '0, 0); tick();
    step(0,0,1,0, '0, 0); tick();
    step(0,0,1,0, '0, 0); tick();
    step(0,0,0,0, '0, 0);
    check("full_valid", inst_valid, 1'b1);
    check("full_hold", pc_hold, 1'b1);
    tick();
    step(0,1,0,1, 32'h80, 0);
    check("fp_valid", inst_valid, 1'b0);
    check("fp_hold", pc_hold, 1'b0);
    tick();
    step(0,0,0,1, '0, 0);
    check("fp_empty", inst_valid, 1'b0);
    tick();
    step(0,0,1,1, '0, 0);
    check("fp_addr", mem_addr, 32'h80);
    check("fp_empty2", inst_valid, 1'b0);
    tick();
    step(0,0,0,1, '0, 0);
    check("fp_ipc", inst_pc, 32'h80);
    tick();

    // Reset in REQ with one entry queued
    do_reset(32'h8);
    step(0,0,0,0, '0, 0); tick();
    step(0,0,1,0, '0, 0); tick();
    step(0,0,0,0, '0, 0);
    check("pre_rst_valid", inst_valid, 1'b1);
    check("pre_rst_ipc", inst_pc, 32'h8);
    check("pre_rst_req", mem_req, 1'b1);
    #2;
    do_reset(32'h30);
    step(0,0,0,0, '0, 0); tick();
    step(0,0,0,0, '0, 0);
    check("post_rst_addr", mem_addr, 32'h30);
    tick();

    // Randomized traffic against the model
    do_reset($urandom);
    for (int seg = 0; seg < 12; seg++) begin
      case (seg % 3)
        0:       rp = 20;
        1:       rp = 60;
        default: rp = 95;
      endcase
      for (int c = 0; c < 200; c++) begin
        step($urandom_range(0, 9) == 0,
             $urandom_range(0, 11) == 0,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 99) < rp,
             $urandom, 1'b0);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
